// File: rtl/bus_cmd_ctrl.sv
// rtl/bus_cmd_ctrl.sv - 8288-style bus command controller with programmable width, wait states and timeout
// Option macro: BUS_CMD_ADV_WRITE_EN (write commands also assert in T1)
module bus_cmd_ctrl #(
    parameter int CMD_CYCLES = 2,
    parameter int MAX_WAIT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] s_n,
    input  logic       aen_n,
    input  logic       cen,
    input  logic       rdy,
    output logic       mrdc_n,
    output logic       mwtc_n,
    output logic       iorc_n,
    output logic       iowc_n,
    output logic       inta_n,
    output logic       ale,
    output logic       den,
    output logic       dtr,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(CMD_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CMD_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_T1, S_TC, S_TE} state_t;
    typedef enum logic [2:0] {TY_NONE, TY_INTA, TY_IOR, TY_IOW, TY_MRD, TY_MWT} typ_t;

    state_t          state_q, state_d;
    typ_t            typ_q, dec_typ;
    logic [CW-1:0]   cnt_q;
    logic [WW-1:0]   wcnt_q;
    logic            to_flag_q;
    logic            req;
    logic            cnt_done;
    logic            is_rd, is_wr;
    logic            cmd_on;
    logic            ale_raw, den_raw, dtr_raw, to_raw;

    always_comb begin
        dec_typ = TY_NONE;
        case (s_n)
            3'b000:         dec_typ = TY_INTA;
            3'b001:         dec_typ = TY_IOR;
            3'b010:         dec_typ = TY_IOW;
            3'b100, 3'b101: dec_typ = TY_MRD;
            3'b110:         dec_typ = TY_MWT;
            default:        dec_typ = TY_NONE;
        endcase
    end

    assign req      = !aen_n && (dec_typ != TY_NONE);
    assign cnt_done = (cnt_q >= CNT_LAST);
    assign is_rd    = (typ_q == TY_INTA) || (typ_q == TY_IOR) || (typ_q == TY_MRD);
    assign is_wr    = (typ_q == TY_IOW) || (typ_q == TY_MWT);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req) state_d = S_T1;
            S_T1:   state_d = S_TC;
            S_TC: begin
                if (cnt_done && (rdy || (wcnt_q == WAIT_LAST)))
                    state_d = S_TE;
            end
            S_TE:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters saturate by construction: the FSM leaves TC before either could pass its limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            typ_q     <= TY_NONE;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            to_flag_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req) typ_q <= dec_typ;
                S_T1: begin
                    cnt_q  <= '0;
                    wcnt_q <= '0;
                end
                S_TC: begin
                    if (!cnt_done)
                        cnt_q <= cnt_q + 1'b1;
                    else if (!rdy) begin
                        if (wcnt_q == WAIT_LAST) to_flag_q <= 1'b1;
                        else                     wcnt_q    <= wcnt_q + 1'b1;
                    end
                end
                S_TE: begin
                    to_flag_q <= 1'b0;
                    typ_q     <= TY_NONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_on  = 1'b0;
        ale_raw = 1'b0;
        den_raw = 1'b0;
        dtr_raw = 1'b1;
        to_raw  = 1'b0;
        case (state_q)
            S_IDLE: ale_raw = req;
            S_T1: begin
`ifdef BUS_CMD_ADV_WRITE_EN
                cmd_on  = is_rd || is_wr;
`else
                cmd_on  = is_rd;
`endif
                den_raw = is_wr;
                dtr_raw = !is_rd;
            end
            S_TC: begin
                cmd_on  = 1'b1;
                den_raw = 1'b1;
                dtr_raw = !is_rd;
            end
            S_TE:   to_raw = to_flag_q;
            default: ;
        endcase
    end

    // cen gates only the pins; the FSM keeps sequencing underneath.
    assign mrdc_n  = !(cen && cmd_on && (typ_q == TY_MRD));
    assign mwtc_n  = !(cen && cmd_on && (typ_q == TY_MWT));
    assign iorc_n  = !(cen && cmd_on && (typ_q == TY_IOR));
    assign iowc_n  = !(cen && cmd_on && (typ_q == TY_IOW));
    assign inta_n  = !(cen && cmd_on && (typ_q == TY_INTA));
    assign ale     = cen && ale_raw;
    assign den     = cen && den_raw;
    assign dtr     = !cen || dtr_raw;
    assign timeout = cen && to_raw;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_cmd_ctrl.sv
// tb/tb_bus_cmd_ctrl.sv - directed self-checking bench for bus_cmd_ctrl (default parameters)
module tb_bus_cmd_ctrl;

    logic       clk, rst, aen_n, cen, rdy;
    logic [2:0] s_n;
    logic       mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, ale, den, dtr, busy, timeout;
    int         checks = 0;
    int         failures = 0;

    // Vector order: {mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, ale, den, dtr, busy, timeout}
    localparam logic [9:0] IDLE0   = 10'b11111_0_0_1_0_0;
    localparam logic [9:0] ALE1    = 10'b11111_1_0_1_0_0;
    localparam logic [9:0] TE0     = 10'b11111_0_0_1_1_0;
    localparam logic [9:0] TE_TO   = 10'b11111_0_0_1_1_1;
    localparam logic [9:0] MRD_T1  = 10'b01111_0_0_0_1_0;
    localparam logic [9:0] MRD_TC  = 10'b01111_0_1_0_1_0;
    localparam logic [9:0] MWT_TC  = 10'b10111_0_1_1_1_0;
    localparam logic [9:0] IOR_T1  = 10'b11011_0_0_0_1_0;
    localparam logic [9:0] IOR_TC  = 10'b11011_0_1_0_1_0;
    localparam logic [9:0] IOW_TC  = 10'b11101_0_1_1_1_0;
    localparam logic [9:0] INTA_T1 = 10'b11110_0_0_0_1_0;
    localparam logic [9:0] INTA_TC = 10'b11110_0_1_0_1_0;
`ifdef BUS_CMD_ADV_WRITE_EN
    localparam logic [9:0] MWT_T1  = 10'b10111_0_1_1_1_0;
    localparam logic [9:0] IOW_T1  = 10'b11101_0_1_1_1_0;
`else
    localparam logic [9:0] MWT_T1  = 10'b11111_0_1_1_1_0;
    localparam logic [9:0] IOW_T1  = 10'b11111_0_1_1_1_0;
`endif

    bus_cmd_ctrl #(.CMD_CYCLES(2), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .s_n(s_n), .aen_n(aen_n), .cen(cen), .rdy(rdy),
        .mrdc_n(mrdc_n), .mwtc_n(mwtc_n), .iorc_n(iorc_n), .iowc_n(iowc_n), .inta_n(inta_n),
        .ale(ale), .den(den), .dtr(dtr), .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are set 1 time unit after a rising edge; outputs sampled 1 unit later.
    task automatic step(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        #1;
        obs = {mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, ale, den, dtr, busy, timeout};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic passive();
        s_n   = 3'b111;
        aen_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; rdy = 1'b1;
        passive();
        @(posedge clk);
        #1;
        step("reset", IDLE0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("idle%0d", i), IDLE0);

        // Memory read, no waits
        s_n = 3'b101; aen_n = 1'b0;
        step("mrd_ale", ALE1);
        passive();
        step("mrd_t1", MRD_T1);
        step("mrd_tc0", MRD_TC);
        step("mrd_tc1", MRD_TC);
        step("mrd_te", TE0);
        step("mrd_idle", IDLE0);

        // Memory write; status changes after IDLE must be ignored
        s_n = 3'b110; aen_n = 1'b0;
        step("mwt_ale", ALE1);
        s_n = 3'b000; aen_n = 1'b1;
        step("mwt_t1", MWT_T1);
        step("mwt_tc0", MWT_TC);
        step("mwt_tc1", MWT_TC);
        step("mwt_te", TE0);
        passive();
        step("mwt_idle", IDLE0);

        // IO read with 4 wait states; rdy low before the minimum count is ignored
        s_n = 3'b001; aen_n = 1'b0; rdy = 1'b0;
        step("ior_ale", ALE1);
        passive();
        step("ior_t1", IOR_T1);
        for (int i = 0; i < 5; i++) step($sformatf("ior_tc%0d", i), IOR_TC);
        rdy = 1'b1;
        step("ior_tc5", IOR_TC);
        rdy = 1'b0;
        step("ior_te", TE0);
        step("ior_idle", IDLE0);

        // IO write, rdy never rises: 17 TC cycles then a timeout pulse
        s_n = 3'b010; aen_n = 1'b0;
        step("iow_ale", ALE1);
        passive();
        step("iow_t1", IOW_T1);
        for (int i = 0; i < 17; i++) step($sformatf("iow_tc%0d", i), IOW_TC);
        step("iow_te_timeout", TE_TO);
        step("iow_idle", IDLE0);
        rdy = 1'b1;

        // INTA interrupted by reset in TC, then a clean restart
        s_n = 3'b000; aen_n = 1'b0;
        step("inta_ale", ALE1);
        passive();
        step("inta_t1", INTA_T1);
        rst = 1'b1;
        step("inta_tc_rst", INTA_TC);
        rst = 1'b0;
        step("inta_after_rst", IDLE0);
        s_n = 3'b000; aen_n = 1'b0;
        step("inta2_ale", ALE1);
        passive();
        step("inta2_t1", INTA_T1);
        step("inta2_tc0", INTA_TC);
        step("inta2_tc1", INTA_TC);
        step("inta2_te", TE0);
        step("inta2_idle", IDLE0);

        // cen=0 masks pins but the cycle still runs (busy 4 cycles)
        cen = 1'b0;
        s_n = 3'b101; aen_n = 1'b0;
        step("cen0_idle", IDLE0);
        passive();
        for (int i = 0; i < 4; i++) step($sformatf("cen0_busy%0d", i), TE0);
        step("cen0_done", IDLE0);
        cen = 1'b1;
        step("cen1_idle", IDLE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
